// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO placed directly in front of the UART transmitter. Host logic pushes
// bytes at up to one per clock. A three-state drain FSM (IDLE -> START -> WAIT)
// hands the bytes to the transmitter one at a time over its ready / start /
// taken handshake. This decouples bursty producers from the fixed serial rate.
//
// Parameters
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 entries (legal 1..10, default 4)
//
// Ports
//   iClk       clock
//   iRst       synchronous active-high reset, shared with the transmitter
//   iWrData    byte to enqueue
//   iWr        enqueue strobe, at most one byte per cycle
//   oFull      FIFO holds 2**DEPTH_LOG2 entries
//   oEmpty     FIFO holds no entries
//   oOverflow  sticky flag: a write was dropped because the FIFO was full
//   iClrOvf    clears oOverflow (a simultaneous dropped write takes priority)
//   oTxData    byte presented to the transmitter, held stable until taken
//   oTxStart   one-cycle start strobe to the transmitter
//   iTxReady   transmitter idle
//   iTxTaken   one-cycle pulse: transmitter latched oTxData
//   oLevel     occupancy, wrPtr - rdPtr (only when UART_TX_FIFO_LEVEL_EN
//              is defined)
//
// Build option
//   UART_TX_FIFO_LEVEL_EN  adds the oLevel occupancy port. Without it the port
//                          and its subtractor are absent, and all other
//                          behaviour is unchanged.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [7:0]            iWrData,
  input  logic                  iWr,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oOverflow,
  input  logic                  iClrOvf,
  output logic [7:0]            oTxData,
  output logic                  oTxStart,
  input  logic                  iTxReady,
  input  logic                  iTxTaken
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   oLevel
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2:0]   wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2:0]   rdPtr_q, rdPtr_d;
  logic [7:0]            txData_q, txData_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            mem_q [DEPTH];

  logic                  wrEn;
  logic [DEPTH_LOG2-1:0] wrIdx;
  logic [DEPTH_LOG2-1:0] rdIdx;

  assign wrIdx = wrPtr_q[DEPTH_LOG2-1:0];
  assign rdIdx = rdPtr_q[DEPTH_LOG2-1:0];

  // The extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
  assign oEmpty = (wrPtr_q == rdPtr_q);
  assign oFull  = (wrPtr_q[DEPTH_LOG2] != rdPtr_q[DEPTH_LOG2]) &&
                  (wrIdx == rdIdx);

  assign wrEn      = iWr && !oFull;
  assign oTxStart  = (state_q == ST_START);
  assign oTxData   = txData_q;
  assign oOverflow = ovf_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  // Modular subtraction gives the correct count across pointer wrap.
  assign oLevel = wrPtr_q - rdPtr_q;
`endif

  // Next-state logic: drain FSM, pointers, overflow flag
  always_comb begin
    state_d  = state_q;
    rdPtr_d  = rdPtr_q;
    txData_d = txData_q;
    wrPtr_d  = wrPtr_q;
    ovf_d    = ovf_q;

    if (wrEn) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end

    // A dropped write is reported even if a pop frees a slot the same cycle;
    // fullness is judged on the registered pointers only.
    if (iWr && oFull) begin
      ovf_d = 1'b1;
    end else if (iClrOvf) begin
      ovf_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // No bypass: a byte written this cycle is only visible next cycle.
        if (!oEmpty && iTxReady) begin
          txData_d = mem_q[rdIdx];
          state_d  = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The byte stays in the FIFO until the transmitter confirms it.
        if (iTxTaken) begin
          rdPtr_d = rdPtr_q + PTR_ONE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      txData_q <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      txData_q <= txData_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge iClk) begin
    if (wrEn) begin
      mem_q[wrIdx] <= iWrData;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo (DEPTH_LOG2 = 4). A small transmitter model
// answers each start with ready low, then a taken pulse a few cycles later.
// It records every byte presented with oTxStart. The model can be switched
// out so that the steps can drive iTxReady / iTxTaken by hand.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iWrData;
  logic       iWr;
  logic       oFull;
  logic       oEmpty;
  logic       oOverflow;
  logic       iClrOvf;
  logic [7:0] oTxData;
  logic       oTxStart;
  logic       iTxReady;
  logic       iTxTaken;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] oLevel;
`endif

  always #5 iClk = ~iClk;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iWrData   (iWrData),
    .iWr       (iWr),
    .oFull     (oFull),
    .oEmpty    (oEmpty),
    .oOverflow (oOverflow),
    .iClrOvf   (iClrOvf),
    .oTxData   (oTxData),
    .oTxStart  (oTxStart),
    .iTxReady  (iTxReady),
    .iTxTaken  (iTxTaken)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .oLevel    (oLevel)
`endif
  );

  // Transmitter model, or manual handshake when modelEn is low
  logic       modelEn;
  logic       mReady;
  logic       mTaken;
  logic       manReady;
  logic       manTaken;
  int         busy;
  logic [7:0] rxQ [$];

  assign iTxReady = modelEn ? mReady : manReady;
  assign iTxTaken = modelEn ? mTaken : manTaken;

  always @(posedge iClk) begin
    if (iRst) begin
      mReady <= 1'b1;
      mTaken <= 1'b0;
      busy   <= 0;
    end else begin
      mTaken <= 1'b0;
      if (oTxStart) rxQ.push_back(oTxData);
      if (modelEn) begin
        if (oTxStart) begin
          mReady <= 1'b0;
          busy   <= 3;
        end else if (busy > 0) begin
          busy <= busy - 1;
          if (busy == 1) mTaken <= 1'b1;
        end else begin
          mReady <= 1'b1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    iWr     = 1'b1;
    iWrData = d;
    step();
    iWr     = 1'b0;
  endtask

  // Wait until the model has seen 'target' starts and the FIFO is drained.
  task automatic waitDrain(input string tag, input int target, input int maxc);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if (rxQ.size() >= target && oEmpty && iTxReady && !iTxTaken) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(ok), 1);
  endtask

  initial begin
    int base;
    int gap;
    int guard;

    iRst     = 1'b1;
    iWr      = 1'b0;
    iWrData  = 8'h00;
    iClrOvf  = 1'b0;
    modelEn  = 1'b1;
    manReady = 1'b0;
    manTaken = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_start", 32'(oTxStart), 0);
    chk("rst_data",  32'(oTxData), 0);
    chk("rst_empty", 32'(oEmpty), 1);
    chk("rst_full",  32'(oFull), 0);
    chk("rst_ovf",   32'(oOverflow), 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("rst_level", 32'(oLevel), 0);
`endif
    iRst = 1'b0;
    step();

    // Single write into an empty FIFO: start at t+2 for one cycle
    base    = rxQ.size();
    iWr     = 1'b1;
    iWrData = 8'h5A;
    step();
    iWr = 1'b0;
    chk("lat_t1_start", 32'(oTxStart), 0);
    chk("lat_t1_empty", 32'(oEmpty), 0);
    step();
    chk("lat_t2_start", 32'(oTxStart), 1);
    chk("lat_t2_data",  32'(oTxData), 32'h5A);
    step();
    chk("lat_t3_start", 32'(oTxStart), 0);
    waitDrain("lat_drain", base + 1, 100);
    chk("lat_count", 32'(rxQ.size() - base), 1);

    // Three consecutive pushes: three starts, in order
    base = rxQ.size();
    push(8'h41);
    push(8'h42);
    push(8'h43);
    waitDrain("seq3_drain", base + 3, 200);
    repeat (10) step();
    chk("seq3_count", 32'(rxQ.size() - base), 3);
    chk("seq3_b0", 32'(rxQ[base]),     32'h41);
    chk("seq3_b1", 32'(rxQ[base + 1]), 32'h42);
    chk("seq3_b2", 32'(rxQ[base + 2]), 32'h43);
    chk("seq3_empty", 32'(oEmpty), 1);

    // Fill with the transmitter stalled, then overflow
    modelEn  = 1'b0;
    manReady = 1'b0;
    base     = rxQ.size();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    chk("fill_full", 32'(oFull), 1);
    chk("fill_ovf0", 32'(oOverflow), 0);
    push(8'h99);
    chk("ovf_set",  32'(oOverflow), 1);
    chk("ovf_full", 32'(oFull), 1);
    iClrOvf = 1'b1;
    step();
    iClrOvf = 1'b0;
    chk("ovf_clr", 32'(oOverflow), 0);
    iClrOvf = 1'b1;
    iWr     = 1'b1;
    iWrData = 8'h99;
    step();
    iClrOvf = 1'b0;
    iWr     = 1'b0;
    chk("ovf_set_wins", 32'(oOverflow), 1);
    iClrOvf = 1'b1;
    step();
    iClrOvf = 1'b0;
    chk("ovf_clr2", 32'(oOverflow), 0);
    modelEn = 1'b1;
    waitDrain("fill_drain", base + 16, 400);
    chk("fill_count", 32'(rxQ.size() - base), 16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("fill_b%0d", k), 32'(rxQ[base + k]), 32'(8'h80 + k));

    // Write coinciding with a pop at occupancy 5
    modelEn  = 1'b0;
    manReady = 1'b0;
    base     = rxQ.size();
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    manReady = 1'b1;
    step();
    manReady = 1'b0;
    chk("wp_start", 32'(oTxStart), 1);
    step();
    chk("wp_wait_nostart", 32'(oTxStart), 0);
    iWr      = 1'b1;
    iWrData  = 8'h15;
    manTaken = 1'b1;
    step();
    iWr      = 1'b0;
    manTaken = 1'b0;
    chk("wp_empty", 32'(oEmpty), 0);
    chk("wp_full",  32'(oFull), 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("wp_level", 32'(oLevel), 5);
`endif
    for (int i = 0; i < 10; i++) push(8'(8'h16 + i));
    chk("wp_occ15_notfull", 32'(oFull), 0);
    push(8'h20);
    chk("wp_occ16_full", 32'(oFull), 1);
    modelEn = 1'b1;
    waitDrain("wp_drain", base + 17, 500);
    chk("wp_count", 32'(rxQ.size() - base), 17);
    for (int k = 0; k < 17; k++)
      chk($sformatf("wp_b%0d", k), 32'(rxQ[base + k]), 32'(8'h10 + k));

    // Reset while waiting for taken with 3 bytes queued
    modelEn  = 1'b0;
    manReady = 1'b0;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    manReady = 1'b1;
    step();
    manReady = 1'b0;
    step();
    chk("rw_hold_data", 32'(oTxData), 32'h61);
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    chk("rw_start", 32'(oTxStart), 0);
    chk("rw_empty", 32'(oEmpty), 1);
    chk("rw_data",  32'(oTxData), 0);
    chk("rw_full",  32'(oFull), 0);
    base     = rxQ.size();
    manReady = 1'b1;
    repeat (10) step();
    manReady = 1'b0;
    chk("rw_nostart", 32'(rxQ.size() - base), 0);

    // 40-byte stream with random gaps; pointers wrap twice from reset
    modelEn = 1'b1;
    base    = rxQ.size();
    for (int i = 0; i < 40; i++) begin
      guard = 0;
      while (oFull && guard < 200) begin
        step();
        guard++;
      end
      push(8'(i));
      gap = int'($urandom_range(0, 3));
      repeat (gap) step();
    end
    waitDrain("str_drain", base + 40, 2000);
    chk("str_count", 32'(rxQ.size() - base), 40);
    for (int k = 0; k < 40; k++)
      chk($sformatf("str_b%0d", k), 32'(rxQ[base + k]), 32'(k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
